// File: rtl/mcu_link.sv
// ----------------------------------------------------------------------------
// mcu_link -- UART link from the radio to its housekeeping MCU.
//
// Reports level changes on N_EVT asynchronous event inputs as one-byte codes
// and sends a version burst (RADIO_ID followed by FW_VERSION, MSB byte first)
// on request. A boot announcement (version burst, then one current-state byte
// per channel) is sent after every reset. The bytes pass through a small
// inferred-RAM FIFO into an 8N1 serializer.
//
// Optional receiver: define MCU_LINK_RX_EN to build an 8N1 deserialiser on
// uart_rx. A received 8'h3F then also requests a version burst. Without the
// macro, uart_rx is ignored and the rx_* outputs are held at 0.
//
// Ports
//   clk         in   single clock
//   rst         in   synchronous, active-high reset
//   uart_tx     out  serial line to the MCU, idle high
//   uart_rx     in   serial line from the MCU (asynchronous)
//   evt_in      in   [N_EVT] asynchronous event levels, bit 0 is PTT
//   ver_req     in   one-cycle pulse requesting a version burst
//   tx_busy     out  FIFO non-empty or serializer active
//   rx_byte     out  [8] last good received byte
//   rx_valid    out  one-cycle strobe, rx_byte updated
//   rx_frm_err  out  one-cycle strobe, stop bit received as 0
// ----------------------------------------------------------------------------
module mcu_link #(
    parameter int          CLKS_PER_BIT = 6400,
    parameter int          N_EVT        = 1,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [7:0]  RADIO_ID     = 8'h33,
    parameter logic [63:0] FW_VERSION   = 64'b0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             uart_tx,
    input  logic             uart_rx,
    input  logic [N_EVT-1:0] evt_in,
    input  logic             ver_req,
    output logic             tx_busy,
    output logic [7:0]       rx_byte,
    output logic             rx_valid,
    output logic             rx_frm_err
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    // ------------------------------------------------------------------
    // Event input synchronisers
    // ------------------------------------------------------------------
    logic [N_EVT-1:0] evt_meta_reg;
    logic [N_EVT-1:0] evt_sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_meta_reg <= '0;
            evt_sync_reg <= '0;
        end else begin
            evt_meta_reg <= evt_in;
            evt_sync_reg <= evt_meta_reg;
        end
    end

    // Code for the current synchronised level of each channel.
    logic [7:0] code_now [N_EVT];

    generate
        for (genvar gi = 0; gi < N_EVT; gi++) begin : g_code
            assign code_now[gi] = evt_sync_reg[gi] ? 8'(8'h24 + 2 * gi)
                                                   : 8'(8'h23 + 2 * gi);
        end
    endgenerate

    // Version burst bytes: RADIO_ID, then FW_VERSION most significant first.
    logic [7:0] ver_byte [9];

    assign ver_byte[0] = RADIO_ID;

    generate
        for (genvar gi = 1; gi < 9; gi++) begin : g_ver
            assign ver_byte[gi] = FW_VERSION[(8 - gi) * 8 +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Receiver (optional) -- provides the 3F version request source
    // ------------------------------------------------------------------
    logic rx_ver_req;

`ifdef MCU_LINK_RX_EN
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    rx_state_t   rx_state_reg;
    logic        rx_meta_reg;
    logic        rx_sync_reg;
    logic        rx_prev_reg;
    logic [15:0] rx_cnt_reg;
    logic [2:0]  rx_bit_reg;
    logic [7:0]  rx_shift_reg;
    logic [7:0]  rx_byte_reg;
    logic        rx_valid_reg;
    logic        rx_frm_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg   <= R_IDLE;
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            rx_prev_reg    <= 1'b1;
            rx_cnt_reg     <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_byte_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            rx_frm_err_reg <= 1'b0;
        end else begin
            rx_meta_reg    <= uart_rx;
            rx_sync_reg    <= rx_meta_reg;
            rx_prev_reg    <= rx_sync_reg;
            rx_valid_reg   <= 1'b0;
            rx_frm_err_reg <= 1'b0;
            case (rx_state_reg)
                R_IDLE: begin
                    if (rx_prev_reg && !rx_sync_reg) begin
                        rx_state_reg <= R_START;
                        rx_cnt_reg   <= '0;
                    end
                end
                R_START: begin
                    // Half a bit in: a line that is high again was a glitch.
                    if (rx_cnt_reg == HALF_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_bit_reg   <= '0;
                        rx_state_reg <= rx_sync_reg ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 16'd1;
                    end
                end
                R_DATA: begin
                    // Counting starts at mid start bit, so every sample is mid-bit.
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                        if (rx_bit_reg == 3'd7) begin
                            rx_state_reg <= R_STOP;
                        end else begin
                            rx_bit_reg <= rx_bit_reg + 3'd1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= R_IDLE;
                        if (rx_sync_reg) begin
                            rx_byte_reg  <= rx_shift_reg;
                            rx_valid_reg <= 1'b1;
                        end else begin
                            rx_frm_err_reg <= 1'b1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 16'd1;
                    end
                end
            endcase
        end
    end

    assign rx_byte    = rx_byte_reg;
    assign rx_valid   = rx_valid_reg;
    assign rx_frm_err = rx_frm_err_reg;
    assign rx_ver_req = rx_valid_reg && (rx_byte_reg == 8'h3F);
`else
    logic unused_uart_rx;

    assign unused_uart_rx = uart_rx;
    assign rx_byte        = 8'h00;
    assign rx_valid       = 1'b0;
    assign rx_frm_err     = 1'b0;
    assign rx_ver_req     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Producer: boot announcement, version bursts and event codes
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {P_IDLE, P_VER, P_STATE} prod_state_t;

    prod_state_t      prod_state_reg;
    logic [3:0]       idx_reg;
    logic             boot_reg;
    logic             ver_pend_reg;
    logic [N_EVT-1:0] last_rep_reg;
    logic [N_EVT-1:0] pending_reg;
    logic [N_EVT-1:0] last_rep_next;
    logic [N_EVT-1:0] svc_mask;
    logic             svc_any;
    logic [3:0]       svc_idx;
    logic [3:0]       sel_idx;
    logic [7:0]       code_sel;
    logic             ver_take;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             upd_en;
    logic             full_reg;
    logic             empty_reg;

    // A pending channel is only serviced while its level still differs,
    // so a level that has already returned is never reported.
    assign svc_mask = pending_reg & (evt_sync_reg ^ last_rep_reg);
    assign ver_take = (prod_state_reg == P_IDLE) && ver_pend_reg;

    always_comb begin
        svc_any = |svc_mask;
        svc_idx = '0;
        for (int i = N_EVT - 1; i >= 0; i--) begin
            if (svc_mask[i]) begin
                svc_idx = 4'(i);
            end
        end
    end

    always_comb begin
        sel_idx  = (prod_state_reg == P_STATE) ? idx_reg : svc_idx;
        code_sel = '0;
        for (int i = 0; i < N_EVT; i++) begin
            if (sel_idx == 4'(i)) begin
                code_sel = code_now[i];
            end
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        upd_en  = 1'b0;
        case (prod_state_reg)
            P_VER: begin
                wr_en   = !full_reg;
                wr_data = ver_byte[idx_reg];
            end
            P_STATE: begin
                wr_en   = !full_reg;
                upd_en  = !full_reg;
                wr_data = code_sel;
            end
            default: begin
                // A pending version request outranks any event.
                if (!ver_pend_reg && svc_any && !full_reg) begin
                    wr_en   = 1'b1;
                    upd_en  = 1'b1;
                    wr_data = code_sel;
                end
            end
        endcase
    end

    always_comb begin
        last_rep_next = last_rep_reg;
        for (int i = 0; i < N_EVT; i++) begin
            if (upd_en && (sel_idx == 4'(i))) begin
                last_rep_next[i] = evt_sync_reg[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset lands directly in VER so the boot burst starts on the
            // first cycle after release.
            prod_state_reg <= P_VER;
            idx_reg        <= '0;
            boot_reg       <= 1'b1;
            ver_pend_reg   <= 1'b0;
            last_rep_reg   <= '0;
            pending_reg    <= '0;
        end else begin
            last_rep_reg <= last_rep_next;
            pending_reg  <= evt_sync_reg ^ last_rep_next;

            // Requests seen while a version burst is starting or running
            // are folded into that burst.
            if ((prod_state_reg == P_VER) || ver_take) begin
                ver_pend_reg <= 1'b0;
            end else if (ver_req || rx_ver_req) begin
                ver_pend_reg <= 1'b1;
            end

            case (prod_state_reg)
                P_VER: begin
                    if (!full_reg) begin
                        if (idx_reg == 4'd8) begin
                            idx_reg        <= '0;
                            boot_reg       <= 1'b0;
                            prod_state_reg <= boot_reg ? P_STATE : P_IDLE;
                        end else begin
                            idx_reg <= idx_reg + 4'd1;
                        end
                    end
                end
                P_STATE: begin
                    if (!full_reg) begin
                        if (idx_reg == 4'(N_EVT - 1)) begin
                            idx_reg        <= '0;
                            prod_state_reg <= P_IDLE;
                        end else begin
                            idx_reg <= idx_reg + 4'd1;
                        end
                    end
                end
                default: begin
                    if (ver_take) begin
                        idx_reg        <= '0;
                        prod_state_reg <= P_VER;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX byte FIFO: pointers carry one extra wrap bit
    // ------------------------------------------------------------------
    logic [7:0]  mem_reg [FIFO_DEPTH];
    logic [7:0]  rd_data_reg;
    logic [AW:0] wptr_reg;
    logic [AW:0] rptr_reg;
    logic [AW:0] wptr_next;
    logic [AW:0] rptr_next;
    logic        rd_en;

    assign wptr_next = wptr_reg + {{AW{1'b0}}, wr_en};
    assign rptr_next = rptr_reg + {{AW{1'b0}}, rd_en};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_reg <= mem_reg[rptr_reg[AW-1:0]];
        end
    end

    // Flags come from the next pointers, so a read and a write in the same
    // cycle leave them consistent.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            full_reg  <= (wptr_next[AW] != rptr_next[AW]) &&
                         (wptr_next[AW-1:0] == rptr_next[AW-1:0]);
            empty_reg <= (wptr_next == rptr_next);
        end
    end

    // ------------------------------------------------------------------
    // 8N1 serializer
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

    ser_state_t  ser_state_reg;
    logic [15:0] tx_cnt_reg;
    logic [2:0]  tx_bit_reg;
    logic [7:0]  tx_shift_reg;
    logic        uart_tx_reg;
    logic        bit_done;

    assign bit_done = (tx_cnt_reg == BIT_LAST);

    // The next byte is fetched in the last stop-bit cycle so frames run
    // back to back; the read data is only needed at the end of the start bit.
    assign rd_en = !empty_reg &&
                   ((ser_state_reg == S_IDLE) ||
                    ((ser_state_reg == S_STOP) && bit_done));

    always_ff @(posedge clk) begin
        if (rst) begin
            ser_state_reg <= S_IDLE;
            tx_cnt_reg    <= '0;
            tx_bit_reg    <= '0;
            tx_shift_reg  <= '0;
            uart_tx_reg   <= 1'b1;
        end else begin
            case (ser_state_reg)
                S_IDLE: begin
                    if (rd_en) begin
                        ser_state_reg <= S_START;
                        tx_cnt_reg    <= '0;
                        uart_tx_reg   <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        ser_state_reg <= S_DATA;
                        tx_cnt_reg    <= '0;
                        tx_bit_reg    <= '0;
                        tx_shift_reg  <= {1'b0, rd_data_reg[7:1]};
                        uart_tx_reg   <= rd_data_reg[0];
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        tx_cnt_reg <= '0;
                        if (tx_bit_reg == 3'd7) begin
                            ser_state_reg <= S_STOP;
                            uart_tx_reg   <= 1'b1;
                        end else begin
                            tx_bit_reg   <= tx_bit_reg + 3'd1;
                            uart_tx_reg  <= tx_shift_reg[0];
                            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 16'd1;
                    end
                end
                default: begin
                    if (bit_done) begin
                        tx_cnt_reg <= '0;
                        if (rd_en) begin
                            ser_state_reg <= S_START;
                            uart_tx_reg   <= 1'b0;
                        end else begin
                            ser_state_reg <= S_IDLE;
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 16'd1;
                    end
                end
            endcase
        end
    end

    assign uart_tx = uart_tx_reg;
    assign tx_busy = !empty_reg || (ser_state_reg != S_IDLE);

endmodule
